// File: rtl/kappa3_seq_controller_if.sv
// Memory bus between the KAPPA3 sequencer (master) and the memory port (slave).
interface kappa3_seq_controller_if;
  logic       mem_sel;
  logic       mem_read;
  logic       mem_write;
  logic [3:0] mem_wrbits;
  logic       mem_ready;

  modport master (output mem_sel, mem_read, mem_write, mem_wrbits, input mem_ready);
  modport slave  (input mem_sel, mem_read, mem_write, mem_wrbits, output mem_ready);
endinterface

// File: rtl/kappa3_seq_controller.sv
// KAPPA3 multi-cycle sequencer: IF/DE/EX/WB control FSM for an RV32I datapath,
// with a memory-wait timeout and a sticky halt state.
module kappa3_seq_controller #(
  parameter int XLEN     = 32,
  parameter int TO_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  input  logic [31:0]             ir,
  input  logic [XLEN-1:0]         alu_out,
  kappa3_seq_controller_if.master bus,
  output logic [3:0]              phase,
  output logic                    pc_sel,
  output logic                    pc_ld,
  output logic                    ir_ld,
  output logic                    rd_ld,
  output logic                    a_ld,
  output logic                    b_ld,
  output logic                    a_sel,
  output logic                    b_sel,
  output logic                    c_ld,
  output logic [4:0]              rs1_addr,
  output logic [4:0]              rs2_addr,
  output logic [4:0]              rd_addr,
  output logic [1:0]              rd_sel,
  output logic [XLEN-1:0]         imm,
  output logic [3:0]              alu_ctl,
  output logic                    halted,
  output logic [1:0]              cause
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // The last count value at which a still-waiting access gives up.
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(2**TO_WIDTH - 2);

  typedef enum logic [2:0] {S_IDLE, S_IF, S_DE, S_EX, S_WB, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]          cause_q, cause_d;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [4:0]         rd;
  logic signed [31:0] imm_dec;
  logic [3:0]         op_ctl;
  logic [3:0]         br_ctl;
  logic [3:0]         store_mask;
  logic               wb_done;
  logic               mem_wait;
  logic               unused_alu_bits;

  assign opcode          = ir[6:0];
  assign funct3          = ir[14:12];
  assign rd              = ir[11:7];
  assign br_ctl          = funct3[2] ? {1'b0, funct3} : {3'b001, funct3[0]};
  assign halted          = (state_q == S_HALT);
  assign cause           = cause_q;
  assign unused_alu_bits = ^alu_out[XLEN-1:2];

  always_comb begin
    imm_dec = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: imm_dec = {ir[31:12], 12'b0};
      OP_JAL:           imm_dec = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      OP_STORE:         imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:        imm_dec = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      default:          imm_dec = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  // Only register-register ops use ir[30] to pick SUB; both shift forms use it for SRA.
  always_comb begin
    op_ctl = 4'b1000;
    case (funct3)
      3'b000: op_ctl = (opcode == OP_OP && ir[30]) ? 4'b1001 : 4'b1000;
      3'b001: op_ctl = 4'b1101;
      3'b010: op_ctl = 4'b0100;
      3'b011: op_ctl = 4'b0110;
      3'b100: op_ctl = 4'b1010;
      3'b101: op_ctl = ir[30] ? 4'b1111 : 4'b1110;
      3'b110: op_ctl = 4'b1011;
      3'b111: op_ctl = 4'b1100;
    endcase
  end

  // A zero mask marks a misaligned store, which retires without touching memory.
  always_comb begin
    store_mask = 4'b0000;
    case (funct3[1:0])
      2'b00: store_mask = 4'b0001 << alu_out[1:0];
      2'b01: begin
        if (alu_out[1:0] == 2'b00)      store_mask = 4'b0011;
        else if (alu_out[1:0] == 2'b10) store_mask = 4'b1100;
      end
      2'b10: if (alu_out[1:0] == 2'b00) store_mask = 4'b1111;
      default: store_mask = 4'b0000;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    to_cnt_d       = to_cnt_q;
    cause_d        = cause_q;
    phase          = 4'b0000;
    pc_sel         = 1'b0;
    pc_ld          = 1'b0;
    ir_ld          = 1'b0;
    rd_ld          = 1'b0;
    a_ld           = 1'b0;
    b_ld           = 1'b0;
    a_sel          = 1'b0;
    b_sel          = 1'b0;
    c_ld           = 1'b0;
    rs1_addr       = 5'd0;
    rs2_addr       = 5'd0;
    rd_addr        = 5'd0;
    rd_sel         = 2'b00;
    imm            = '0;
    alu_ctl        = 4'b0000;
    bus.mem_sel    = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_wrbits = 4'b0000;
    wb_done        = 1'b0;
    mem_wait       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d  = S_IF;
          to_cnt_d = '0;
        end
      end
      S_IF: begin
        phase        = 4'b0001;
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_ld   = 1'b1;
          state_d = S_DE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_HALT;
          cause_d = 2'b11;
        end else begin
          to_cnt_d = to_cnt_q + TO_WIDTH'(1);
        end
      end
      S_DE: begin
        phase    = 4'b0010;
        a_ld     = 1'b1;
        b_ld     = 1'b1;
        rs1_addr = ir[19:15];
        rs2_addr = ir[24:20];
        imm      = XLEN'(imm_dec);
        case (opcode)
          OP_SYSTEM: begin
            state_d = S_HALT;
            cause_d = 2'b01;
          end
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
          OP_LOAD, OP_STORE, OP_IMM, OP_OP: state_d = S_EX;
          default: begin
            state_d = S_HALT;
            cause_d = 2'b10;
          end
        endcase
      end
      S_EX: begin
        phase    = 4'b0100;
        c_ld     = 1'b1;
        state_d  = S_WB;
        to_cnt_d = '0;
        case (opcode)
          OP_LUI: b_sel = 1'b1;
          OP_AUIPC, OP_JAL, OP_BRANCH: begin
            a_sel   = 1'b1;
            b_sel   = 1'b1;
            alu_ctl = 4'b1000;
          end
          OP_JALR, OP_LOAD, OP_STORE: begin
            b_sel   = 1'b1;
            alu_ctl = 4'b1000;
          end
          OP_IMM: begin
            b_sel   = 1'b1;
            alu_ctl = op_ctl;
          end
          OP_OP:   alu_ctl = op_ctl;
          default: alu_ctl = 4'b0000;
        endcase
      end
      S_WB: begin
        phase   = 4'b1000;
        rd_addr = rd;
        case (opcode)
          OP_LUI, OP_AUIPC, OP_IMM, OP_OP: begin
            rd_sel  = 2'b10;
            rd_ld   = (rd != 5'd0);
            wb_done = 1'b1;
          end
          OP_JAL, OP_JALR: begin
            rd_sel  = 2'b01;
            rd_ld   = (rd != 5'd0);
            pc_sel  = 1'b1;
            wb_done = 1'b1;
          end
          OP_BRANCH: begin
            alu_ctl = br_ctl;
            pc_sel  = alu_out[0];
            wb_done = 1'b1;
          end
          OP_LOAD: begin
            bus.mem_sel  = 1'b1;
            bus.mem_read = 1'b1;
            if (bus.mem_ready) begin
              rd_ld   = (rd != 5'd0);
              wb_done = 1'b1;
            end else begin
              mem_wait = 1'b1;
            end
          end
          OP_STORE: begin
            bus.mem_sel = 1'b1;
            if (store_mask == 4'b0000) begin
              wb_done = 1'b1;
            end else begin
              bus.mem_write  = 1'b1;
              bus.mem_wrbits = store_mask;
              wb_done        = bus.mem_ready;
              mem_wait       = !bus.mem_ready;
            end
          end
          default: wb_done = 1'b1;
        endcase
        pc_ld = wb_done;
        if (wb_done) begin
          state_d  = run ? S_IF : S_IDLE;
          to_cnt_d = '0;
        end else if (mem_wait) begin
          if (to_cnt_q == TO_LAST) begin
            state_d = S_HALT;
            cause_d = 2'b11;
          end else begin
            to_cnt_d = to_cnt_q + TO_WIDTH'(1);
          end
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      to_cnt_q <= '0;
      cause_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      cause_q  <= cause_d;
    end
  end

endmodule

// File: doc/kappa3_seq_controller.md
KAPPA3_SEQ_CONTROLLER -- requirements
Module: kappa3_seq_controller

Interface
REQ-001 Parameter XLEN, default 32: width of imm and alu_out.
REQ-002 Parameter TO_WIDTH, default 4: memory-wait timeout counter width; limit = 2^TO_WIDTH-1 cycles.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 run  in  1  start/continue enable, sampled in IDLE only.
REQ-006 ir  in  32  instruction register value.
REQ-007 alu_out  in  XLEN  ALU result; bit 0 is the branch condition, bits 1:0 are the store byte offset.
REQ-008 mem_ready  in  1  memory access completes this cycle.
REQ-009 phase  out  4  one-hot phase: 0001 IF, 0010 DE, 0100 EX, 1000 WB; 0000 in IDLE/HALT.
REQ-010 pc_sel, pc_ld, mem_sel, mem_read, mem_write, ir_ld, rd_ld, a_ld, b_ld, a_sel, b_sel, c_ld  out  1 each  datapath controls.
REQ-011 mem_wrbits  out  4  byte-write mask.
REQ-012 rs1_addr, rs2_addr, rd_addr  out  5 each  register addresses.
REQ-013 rd_sel  out  2  writeback source: 00 memory, 01 PC+4, 10 C register.
REQ-014 imm  out  XLEN  sign-extended immediate.
REQ-015 alu_ctl  out  4  ALU function code.
REQ-016 halted  out  1  high in HALT.
REQ-017 cause  out  2  halt cause: 00 none, 01 ECALL/EBREAK, 10 illegal opcode, 11 memory timeout.

Function
REQ-018 FSM states SHALL be IDLE, IF, DE, EX, WB, HALT; all outputs are registered-state decodes, no latches; unassigned controls are 0.
REQ-019 IDLE: run=1 -> IF next cycle; run=0 -> stay in IDLE.
REQ-020 IF: mem_sel=0, mem_read=1; ir_ld=1 only in the cycle with mem_ready=1, which also moves the FSM to DE; otherwise stay in IF.
REQ-021 DE: a_ld=b_ld=1; rs1_addr=ir[19:15], rs2_addr=ir[24:20]; imm by format (U, J, S, B, I with sign from ir[31], extended to XLEN); opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM} -> HALT with cause=10; SYSTEM -> HALT with cause=01; otherwise -> EX.
REQ-022 EX (exactly 1 cycle, c_ld=1) -> WB; alu_ctl: add 1000, sub 1001, xor 1010, or 1011, and 1100, sll 1101, srl 1110, sra 1111, slt 0100, sltu 0110, pass-B 0000.
REQ-023 EX operand selects: LUI b_sel=1 with pass-B; AUIPC, JAL, branch a_sel=1, b_sel=1, add (target); JALR, LOAD, STORE a_sel=0, b_sel=1, add; OP-IMM b_sel=1; OP b_sel=0; ir[30] selects sub/sra.
REQ-024 WB: rd_addr=ir[11:7]; pc_ld=1 in the final WB cycle only; pc_sel=0 (PC+4) unless stated below.
REQ-025 WB LUI/AUIPC/OP/OP-IMM: rd_sel=10, rd_ld=1, single cycle.
REQ-026 WB JAL/JALR: rd_sel=01, rd_ld=1, pc_sel=1.
REQ-027 WB branch: a_sel=b_sel=0; alu_ctl by funct3: BEQ 0010, BNE 0011, BLT 0100, BGE 0101, BLTU 0110, BGEU 0111; pc_sel=alu_out[0].
REQ-028 WB LOAD: mem_sel=1, mem_read=1, rd_sel=00; rd_ld and pc_ld assert only in the mem_ready cycle; stay in WB until then.
REQ-029 WB STORE: mem_sel=1, mem_write=1 until mem_ready.
REQ-030 Store masks: SB 0001 << alu_out[1:0]; SH 0011 for offset 00, 1100 for offset 10; SW 1111.
REQ-031 Misaligned store (SH offset 01/11, SW offset != 00): mem_wrbits=0000 and mem_write=0; the instruction completes as a no-op with pc_ld=1.
REQ-032 Timeout counter SHALL clear on entry to IF or WB and increment each cycle mem_ready=0; reaching the limit -> HALT with cause=11, with no ir_ld or rd_ld.
REQ-033 After WB completes: run=1 -> IF; run=0 -> IDLE.
REQ-034 HALT is sticky until reset; halted=1; cause is held.
REQ-035 rd_ld SHALL be 0 whenever rd_addr=0.

Reset
REQ-036 reset=0 at a clock edge -> state IDLE, phase=0000, timeout counter=0, cause=00, halted=0, all control strobes 0, imm=0, addresses 0; this applies from any state, including mid-memory-wait.

Verification
REQ-037 run=1, ir=ADDI x1,x0,5 (0x00500093), mem_ready=1 always -> phases 0001,0010,0100,1000 in 4 cycles; WB rd_ld=1, rd_addr=1, rd_sel=10, pc_ld=1, pc_sel=0.
REQ-038 LW with mem_ready low for 3 WB cycles -> WB lasts 4 cycles; rd_ld=1 and pc_ld=1 in the 4th cycle only.
REQ-039 SB with alu_out=0x...02 -> mem_wrbits=0100; SH with alu_out=0x...01 -> mem_write=0, pc_ld=1.
REQ-040 BEQ with alu_out[0]=1 in WB -> pc_sel=1, pc_ld=1; with alu_out[0]=0 -> pc_sel=0.
REQ-041 mem_ready held 0 in IF with TO_WIDTH=4 -> HALT after 15 cycles, cause=11, halted=1; ir=0x00000073 -> cause=01; opcode 0x7F -> cause=10.
REQ-042 reset=0 during a WB memory wait -> next cycle IDLE with all outputs 0; no rd_ld and no pc_ld pulse.
